// File: rtl/vga_pkg.sv
// Shared definitions for the VGA palette stage: state encoding, palette
// geometry, timing-flag bundle and the 3-3-2 default colour expansion.
package vga_pkg;

  localparam int PAL_ENTRIES = 256;
  localparam int PAL_WIDTH   = 24;
  localparam int PAL_AW      = 8;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } pal_state_t;

  // Timing flags travelling alongside the palette index
  typedef struct packed {
    logic vsync;
    logic hsync;
    logic visible;
  } sync_t;

  // 3-3-2 index expanded to 8-8-8 by bit replication, so 0 -> black and
  // all-ones -> full white in every channel.
  function automatic logic [PAL_WIDTH-1:0] default_colour(input logic [PAL_AW-1:0] i);
    return {i[7:5], i[7:5], i[7:6],
            i[4:2], i[4:2], i[4:3],
            i[1:0], i[1:0], i[1:0], i[1:0]};
  endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// 256 x 24 simple dual-port palette RAM: one write port, one registered
// read port. Read-first on a same-address collision. Coded for block RAM.
module vga_palette_ram
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [PAL_AW-1:0]    wr_adr,
  input  logic [PAL_WIDTH-1:0] wr_dat,
  input  logic [PAL_AW-1:0]    rd_adr,
  output logic [PAL_WIDTH-1:0] rd_dat
);

  logic [PAL_WIDTH-1:0] mem [PAL_ENTRIES];
  logic [PAL_WIDTH-1:0] rd_dat_q;

  // Write port; no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[wr_adr] <= wr_dat;
  end

  // Registered read; the old word is returned when the write hits the same address
  always_ff @(posedge clk) begin
    if (rst) rd_dat_q <= '0;
    else     rd_dat_q <= mem[rd_adr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/vga_palette.sv
// Palette lookup stage: 8-bit index -> RGB with OUTBITS per channel.
// Two-stage pipeline (RAM read, then truncate/blank), CPU palette write
// via req/ack handshake. Optional default-palette loader compiled in with
// the macro VGA_PALETTE_DEFAULT_EN; without it reset goes straight to RUN.
module vga_palette
  import vga_pkg::*;
#(
  parameter int OUTBITS = 4
) (
  input  logic                 I_clk,
  input  logic                 I_reset,
  input  logic [PAL_AW-1:0]    I_palette_idx,
  input  logic                 I_vsync,
  input  logic                 I_hsync,
  input  logic                 I_visible,
  input  logic                 I_pal_we,
  input  logic [PAL_AW-1:0]    I_pal_adr,
  input  logic [PAL_WIDTH-1:0] I_pal_dat,
  output logic                 O_pal_ack,
  output logic                 O_busy,
  output logic [OUTBITS-1:0]   O_red,
  output logic [OUTBITS-1:0]   O_green,
  output logic [OUTBITS-1:0]   O_blue,
  output logic                 O_vsync,
  output logic                 O_hsync,
  output logic                 O_visible
);

  pal_state_t           state_q;
  logic                 ack_q, ack_d;
  logic                 ram_we;
  logic [PAL_AW-1:0]    ram_adr;
  logic [PAL_WIDTH-1:0] ram_dat;
  logic [PAL_WIDTH-1:0] rd_dat;
  logic                 pal_unused_bits;

  sync_t                flags1_q, flags1_d;
  sync_t                flags2_q, flags2_d;
  logic [OUTBITS-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;

`ifdef VGA_PALETTE_DEFAULT_EN
  pal_state_t           state_d;
  logic [PAL_AW-1:0]    cnt_q, cnt_d;

  // Loader sequencing: walk 0..255 once after reset, then hand over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_LOAD) begin
      cnt_d = PAL_AW'(cnt_q + 1'b1);
      if (cnt_q == PAL_AW'(PAL_ENTRIES - 1)) state_d = ST_RUN;
    end
  end

  // Loader state and counter; reset always restarts the load at entry 0
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign state_q = ST_RUN;
`endif

  assign O_busy = (state_q == ST_LOAD);

  // Write-port mux: loader owns the RAM in LOAD; CPU writes once per request
  // in RUN (a request still high in the ack cycle is not written again)
  always_comb begin
    ram_we  = 1'b0;
    ram_adr = I_pal_adr;
    ram_dat = I_pal_dat;
    ack_d   = 1'b0;
    if (!I_reset) begin
`ifdef VGA_PALETTE_DEFAULT_EN
      if (state_q == ST_LOAD) begin
        ram_we  = 1'b1;
        ram_adr = cnt_q;
        ram_dat = default_colour(cnt_q);
      end else
`endif
      if (I_pal_we && !ack_q) begin
        ram_we = 1'b1;
        ack_d  = 1'b1;
      end
    end
  end

  // Handshake acknowledge, high for exactly one cycle after the write
  always_ff @(posedge I_clk) begin
    if (I_reset) ack_q <= 1'b0;
    else         ack_q <= ack_d;
  end

  assign O_pal_ack = ack_q;

  vga_palette_ram u_ram (
    .clk    (I_clk),
    .rst    (I_reset),
    .we     (ram_we),
    .wr_adr (ram_adr),
    .wr_dat (ram_dat),
    .rd_adr (I_palette_idx),
    .rd_dat (rd_dat)
  );

  // Only the channel MSBs are driven out; the low bits are dropped on purpose
  assign pal_unused_bits = ^rd_dat;

  // Stage 1 flags ride with the RAM read; stage 2 truncates and blanks
  always_comb begin
    flags1_d = '{vsync: I_vsync, hsync: I_hsync, visible: I_visible};
    flags2_d = flags1_q;
    red_d    = '0;
    green_d  = '0;
    blue_d   = '0;
    if (flags1_q.visible && state_q == ST_RUN) begin
      red_d   = rd_dat[23 -: OUTBITS];
      green_d = rd_dat[15 -: OUTBITS];
      blue_d  = rd_dat[7  -: OUTBITS];
    end
  end

  // Pipeline registers, all cleared on reset
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      flags1_q <= '0;
      flags2_q <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else begin
      flags1_q <= flags1_d;
      flags2_q <= flags2_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign O_red     = red_q;
  assign O_green   = green_q;
  assign O_blue    = blue_q;
  assign O_vsync   = flags2_q.vsync;
  assign O_hsync   = flags2_q.hsync;
  assign O_visible = flags2_q.visible;

endmodule

// File: tb/tb_vga_palette.sv
// Directed bench for vga_palette (OUTBITS = 4). Loader checks are only
// compiled when VGA_PALETTE_DEFAULT_EN is defined; handshake, collision,
// blanking and flag-delay checks run in either build and only look at
// entries written by the bench.
module tb_vga_palette;

`ifdef VGA_PALETTE_DEFAULT_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic [7:0]  I_palette_idx;
  logic        I_vsync, I_hsync, I_visible;
  logic        I_pal_we;
  logic [7:0]  I_pal_adr;
  logic [23:0] I_pal_dat;
  logic        O_pal_ack, O_busy;
  logic [3:0]  O_red, O_green, O_blue;
  logic        O_vsync, O_hsync, O_visible;

  int checks = 0;
  int errors = 0;

  always #5 I_clk = ~I_clk;

  vga_palette #(.OUTBITS(4)) dut (
    .I_clk         (I_clk),
    .I_reset       (I_reset),
    .I_palette_idx (I_palette_idx),
    .I_vsync       (I_vsync),
    .I_hsync       (I_hsync),
    .I_visible     (I_visible),
    .I_pal_we      (I_pal_we),
    .I_pal_adr     (I_pal_adr),
    .I_pal_dat     (I_pal_dat),
    .O_pal_ack     (O_pal_ack),
    .O_busy        (O_busy),
    .O_red         (O_red),
    .O_green       (O_green),
    .O_blue        (O_blue),
    .O_vsync       (O_vsync),
    .O_hsync       (O_hsync),
    .O_visible     (O_visible)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk_rgb(input string tag, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b);
    chk({tag, "_r"}, {28'd0, O_red},   {28'd0, r});
    chk({tag, "_g"}, {28'd0, O_green}, {28'd0, g});
    chk({tag, "_b"}, {28'd0, O_blue},  {28'd0, b});
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_rgb(tag, 4'h0, 4'h0, 4'h0);
    chk({tag, "_flags"}, {29'd0, O_vsync, O_hsync, O_visible}, 32'd0);
    chk({tag, "_ack"}, {31'd0, O_pal_ack}, 32'd0);
    chk({tag, "_busy"}, {31'd0, O_busy}, {31'd0, BUSY_RST});
  endtask

  // Full handshake: raise we, wait (bounded) for ack, drop we
  task automatic write_entry(input logic [7:0] adr, input logic [23:0] dat);
    int n;
    I_pal_we  = 1'b1;
    I_pal_adr = adr;
    I_pal_dat = dat;
    n = 0;
    do begin
      tick();
      n++;
    end while (!O_pal_ack && n < 8);
    chk("wr_ack_seen", {31'd0, O_pal_ack}, 32'd1);
    I_pal_we = 1'b0;
    tick();
  endtask

  logic [2:0] pat [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_fall, ack_edge, ack_in_load;
    pat = '{3'b001, 3'b011, 3'b100, 3'b111, 3'b000, 3'b110, 3'b101, 3'b010};

    I_reset = 1'b1;
    I_palette_idx = 8'h00;
    {I_vsync, I_hsync, I_visible} = 3'b000;
    I_pal_we = 1'b0;
    I_pal_adr = 8'h00;
    I_pal_dat = 24'h0;
    repeat (3) tick();
    chk_reset_outs("rst");

`ifdef VGA_PALETTE_DEFAULT_EN
    // Run 100 loader cycles with a visible pixel: must stay blanked
    I_reset = 1'b0;
    I_visible = 1'b1;
    I_palette_idx = 8'hE0;
    repeat (100) tick();
    chk("load_busy", {31'd0, O_busy}, 32'd1);
    chk_rgb("load_blank", 4'h0, 4'h0, 4'h0);
    // Reset mid-load: outputs return to reset values, load restarts
    I_reset = 1'b1;
    repeat (2) tick();
    chk_reset_outs("rst_mid");
    I_reset = 1'b0;
    n = 0;
    while (O_busy && n < 400) begin
      tick();
      n++;
    end
    chk("busy_len", n, 32'd256);
    repeat (2) tick();
    chk_rgb("dflt_e0", 4'hF, 4'h0, 4'h0);

    // Write request raised during LOAD waits for RUN
    I_reset = 1'b1;
    tick();
    I_reset = 1'b0;
    I_visible = 1'b0;
    busy_fall = 0;
    ack_edge = 0;
    ack_in_load = 0;
    for (int e = 1; e <= 270; e++) begin
      tick();
      if (!O_busy && busy_fall == 0) busy_fall = e;
      if (O_pal_ack) begin
        if (ack_edge == 0) ack_edge = e;
        if (O_busy) ack_in_load++;
        I_pal_we = 1'b0;
      end
      if (e == 10) begin
        I_pal_we  = 1'b1;
        I_pal_adr = 8'h20;
        I_pal_dat = 24'h445566;
      end
    end
    chk("load_busy_fall", busy_fall, 32'd256);
    chk("load_ack_edge", ack_edge, 32'd257);
    chk("load_ack_in_load", ack_in_load, 32'd0);
    I_palette_idx = 8'h20;
    I_visible = 1'b1;
    repeat (2) tick();
    chk_rgb("load_wr", 4'h4, 4'h5, 4'h6);
    I_visible = 1'b0;
`else
    I_reset = 1'b0;
    tick();
    chk("run_busy", {31'd0, O_busy}, 32'd0);
`endif

    // Handshake: ack for one cycle, request held in ack cycle not rewritten
    I_pal_we  = 1'b1;
    I_pal_adr = 8'h05;
    I_pal_dat = 24'h123456;
    tick();
    chk("hs_ack1", {31'd0, O_pal_ack}, 32'd1);
    I_pal_dat = 24'hABCDEF;
    tick();
    chk("hs_ack2", {31'd0, O_pal_ack}, 32'd0);
    I_pal_we = 1'b0;
    tick();
    chk("hs_ack3", {31'd0, O_pal_ack}, 32'd0);
    I_palette_idx = 8'h05;
    I_visible = 1'b1;
    repeat (2) tick();
    chk_rgb("hs_look", 4'h1, 4'h3, 4'h5);

    // Collision: same-cycle read of the written address returns the old word
    write_entry(8'h10, 24'hA0B0C0);
    I_palette_idx = 8'h10;
    repeat (2) tick();
    chk_rgb("coll_pre", 4'hA, 4'hB, 4'hC);
    I_pal_we  = 1'b1;
    I_pal_adr = 8'h10;
    I_pal_dat = 24'hFFFFFF;
    tick();
    I_pal_we = 1'b0;
    tick();
    chk_rgb("coll_old", 4'hA, 4'hB, 4'hC);
    tick();
    chk_rgb("coll_new", 4'hF, 4'hF, 4'hF);

    // Flag delay and blanking: pattern driven in cycle c shows in cycle c+2
    write_entry(8'hFF, 24'h8899AA);
    I_palette_idx = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) {I_vsync, I_hsync, I_visible} = pat[k];
      else       {I_vsync, I_hsync, I_visible} = 3'b000;
      tick();
      if (k >= 1 && k <= 8) begin
        chk("flags", {29'd0, O_vsync, O_hsync, O_visible}, {29'd0, pat[k-1]});
        if (pat[k-1][0]) chk_rgb("vis_rgb", 4'h8, 4'h9, 4'hA);
        else             chk_rgb("blank_rgb", 4'h0, 4'h0, 4'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
